// File: rtl/mix_col_seq_if.sv
// Handshake bundle for mix_col_seq: the state-in channel from the round
// controller and the state-out channel back to it.
// Optional macro MC_SEQ_BYPASS_EN adds the in_bypass request bit.
//
// Both channels use the same valid/ready rule: a transfer happens on a
// rising clk edge where valid and ready are both high; the sender holds
// valid and its payload steady until then, and ready may be high at any time.
interface mix_col_seq_if #(
    parameter int NCOL = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [32*NCOL-1:0]   in_state;
`ifdef MC_SEQ_BYPASS_EN
    logic                 in_bypass;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [32*NCOL-1:0]   out_state;

    modport master (
`ifdef MC_SEQ_BYPASS_EN
        output in_bypass,
`endif
        output in_valid, in_mode, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
`ifdef MC_SEQ_BYPASS_EN
        input  in_bypass,
`endif
        input  in_valid, in_mode, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/mix_col_seq.sv
// mix_col_seq: sequencer for a byte-serial MixColumns datapath.
// Takes a whole AES state, streams it column by column (clear, 4 bytes,
// capture) through the external datapath and returns the mixed state.
// Optional macro MC_SEQ_BYPASS_EN: a state accepted with in_bypass set
// goes straight to the output unmixed (final AES round).
// Byte k of a state sits at bits [32*NCOL-1-8k -: 8]; column c = bytes 4c..4c+3.
module mix_col_seq #(
    parameter int NCOL = 4
) (
    input  logic        clk,
    input  logic        rst,
    mix_col_seq_if.slave bus,
    output logic        busy,
    output logic [7:0]  mc_d_in,
    output logic        mc_en,
    output logic        mc_mode,
    output logic        mc_clr,
    input  logic [7:0]  mc_d0,
    input  logic [7:0]  mc_d1,
    input  logic [7:0]  mc_d2,
    input  logic [7:0]  mc_d3,
    output logic [2:0]  state_dbg
);
    localparam int W  = 32 * NCOL;
    localparam int NB = 4 * NCOL;
    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        FEED = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col;
    logic [1:0]      row;
    logic            mode_q;
    logic [7:0]      in_buf  [NB];
    logic [7:0]      out_buf [NB];
    logic            accept;
    logic            take_bypass;
    logic [CW+1:0]   idx;

`ifdef MC_SEQ_BYPASS_EN
    assign take_bypass = bus.in_bypass;
`else
    assign take_bypass = 1'b0;
`endif

    // Status and datapath controls come only from registers (plus rst for clear).
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign busy          = (state != IDLE);
    assign mc_clr        = rst || (state == CLR);
    assign mc_en         = (state == FEED);
    assign idx           = {col, row};
    assign mc_d_in       = (state == FEED) ? in_buf[idx] : 8'h00;
    assign mc_mode       = (state == CLR || state == FEED || state == CAPT) ? mode_q : 1'b0;
    assign state_dbg     = state;
    assign accept        = bus.in_valid && bus.in_ready;

    // Pack the captured bytes back into the output state word.
    always_comb begin
        bus.out_state = '0;
        for (int k = 0; k < NB; k++) begin
            bus.out_state[W-1-8*k -: 8] = out_buf[k];
        end
    end

    // Next-state logic: per column CLR -> 4x FEED -> CAPT, then DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = take_bypass ? DONE : CLR;
            CLR:  state_nxt = FEED;
            FEED: if (row == 2'd3) state_nxt = CAPT;
            CAPT: state_nxt = (col == LAST_COL) ? DONE : CLR;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counters and byte buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                in_buf[k]  <= 8'h00;
                out_buf[k] <= 8'h00;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q <= bus.in_mode;
                        col    <= '0;
                        for (int k = 0; k < NB; k++) begin
                            in_buf[k] <= bus.in_state[W-1-8*k -: 8];
                            if (take_bypass) out_buf[k] <= bus.in_state[W-1-8*k -: 8];
                        end
                    end
                end
                CLR:  row <= 2'd0;
                FEED: row <= row + 2'd1;
                CAPT: begin
                    out_buf[{col, 2'd0}] <= mc_d0;
                    out_buf[{col, 2'd1}] <= mc_d1;
                    out_buf[{col, 2'd2}] <= mc_d2;
                    out_buf[{col, 2'd3}] <= mc_d3;
                    if (col != LAST_COL) col <= col + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_col_seq.sv
// Bench for mix_col_seq with a behavioural byte-serial MixColumns datapath.
// Optional macro MC_SEQ_BYPASS_EN enables the bypass scenario.
module tb_mix_col_seq;
    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V3 = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] mc_d_in;
    logic       mc_en;
    logic       mc_mode;
    logic       mc_clr;
    logic [7:0] mc_d0, mc_d1, mc_d2, mc_d3;
    logic [2:0] state_dbg;

    mix_col_seq_if #(.NCOL(4)) bus ();

    mix_col_seq #(.NCOL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .mc_d_in   (mc_d_in),
        .mc_en     (mc_en),
        .mc_mode   (mc_mode),
        .mc_clr    (mc_clr),
        .mc_d0     (mc_d0),
        .mc_d1     (mc_d1),
        .mc_d2     (mc_d2),
        .mc_d3     (mc_d3),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int mode1_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        en_cnt    <= en_cnt + int'(mc_en);
        clr_cnt   <= clr_cnt + int'(mc_clr);
        mode1_cnt <= mode1_cnt + int'(mc_mode && busy && !bus.out_valid);
    end

    // ---------------- datapath model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Coefficient for input byte j into output row r, keyed by k = (j - r) mod 4.
    function automatic logic [3:0] coef(input logic inv, input logic [1:0] k);
        logic [3:0] c;
        case (k)
            2'd0: c = inv ? 4'd14 : 4'd2;
            2'd1: c = inv ? 4'd11 : 4'd3;
            2'd2: c = inv ? 4'd13 : 4'd1;
            default: c = inv ? 4'd9 : 4'd1;
        endcase
        return c;
    endfunction

    logic [7:0] acc [4];
    logic [1:0] dp_cnt;

    always @(posedge clk) begin
        if (mc_clr) begin
            for (int r = 0; r < 4; r++) acc[r] <= 8'h00;
            dp_cnt <= 2'd0;
        end else if (mc_en) begin
            for (int r = 0; r < 4; r++)
                acc[r] <= acc[r] ^ gmul(mc_d_in, coef(mc_mode, dp_cnt - 2'(r)));
            dp_cnt <= dp_cnt + 2'd1;
        end
    end

    assign mc_d0 = acc[0];
    assign mc_d1 = acc[1];
    assign mc_d2 = acc[2];
    assign mc_d3 = acc[3];

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int t_acc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present a state, wait for the accept, push its expected result.
    task automatic send(input logic [127:0] s, input logic m, input logic [127:0] e);
        int n;
        n = 0;
        bus.in_state = s;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 128'd0, 128'd1);
            return;
        end
        exp_q.push_back(e);
        t_acc = cyc;
        @(negedge clk);
    endtask

    // Wait for a result, compare it, complete the out handshake.
    task automatic collect(input string tag, input int exp_lat);
        int n;
        logic [127:0] e;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 128'd0, 128'd1);
            return;
        end
        if (exp_lat >= 0) check({tag, "_latency"}, 128'(cyc - t_acc), 128'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.out_state, e);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ovalid_drop"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_ready_after"}, 128'(bus.in_ready), 128'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int en0, clr0, m0, n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;
`ifdef MC_SEQ_BYPASS_EN
        bus.in_bypass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_mc_clr", 128'(mc_clr), 128'd1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 128'(state_dbg), 128'd0);
        check("reset_out_valid", 128'(bus.out_valid), 128'd0);
        check("reset_out_state", bus.out_state, 128'd0);
        check("reset_mc_en", 128'(mc_en), 128'd0);
        check("reset_mc_d_in", 128'(mc_d_in), 128'd0);
        check("reset_mc_mode", 128'(mc_mode), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_in_ready", 128'(bus.in_ready), 128'd1);
        check("reset_mc_clr", 128'(mc_clr), 128'd0);

        // Forward mix with pulse counts.
        en0 = en_cnt;
        clr0 = clr_cnt;
        send(V1, 1'b0, V2);
        bus.in_valid = 1'b0;
        collect("fwd", 25);
        check("fwd_en_pulses", 128'(en_cnt - en0), 128'd16);
        check("fwd_clr_pulses", 128'(clr_cnt - clr0), 128'd4);

        // Inverse mix; mc_mode high for all 24 working cycles.
        m0 = mode1_cnt;
        send(V2, 1'b1, V1);
        bus.in_valid = 1'b0;
        collect("inv", 25);
        check("inv_mode_cycles", 128'(mode1_cnt - m0), 128'd24);

        // Back-pressure with a competing in_valid.
        bus.out_ready = 1'b0;
        send(V1, 1'b0, V2);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", 128'(bus.out_valid), 128'd1);
        bus.in_valid = 1'b1;
        bus.in_state = {$urandom, $urandom, $urandom, $urandom};
        bus.in_mode  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_state, V2);
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
        end
        bus.in_valid = 1'b0;
        collect("bp", -1);

        // Reset during FEED of column 2.
        send(V1, 1'b0, V2);
        bus.in_valid = 1'b0;
        n = 0;
        while (cyc != t_acc + 15 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_in_feed", 128'(state_dbg), 128'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_mc_clr", 128'(mc_clr), 128'd1);
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_after_state", 128'(state_dbg), 128'd0);
        check("mid_after_out_valid", 128'(bus.out_valid), 128'd0);
        check("mid_after_in_ready", 128'(bus.in_ready), 128'd1);
        exp_q.delete();
        send(V1, 1'b0, V2);
        bus.in_valid = 1'b0;
        collect("post_rst", 25);

        // Back-to-back with in_valid held high.
        send(V1, 1'b0, V2);
        bus.in_state = V2;
        bus.in_mode  = 1'b1;
        collect("b2b_a", 25);
        send(V2, 1'b1, V1);
        bus.in_valid = 1'b0;
        collect("b2b_b", 25);

`ifdef MC_SEQ_BYPASS_EN
        // Bypass: unmixed pass-through, no datapath activity.
        en0 = en_cnt;
        clr0 = clr_cnt;
        bus.in_bypass = 1'b1;
        send(V3, 1'b0, V3);
        bus.in_bypass = 1'b0;
        bus.in_valid  = 1'b0;
        collect("bypass", 1);
        check("bypass_no_en", 128'(en_cnt - en0), 128'd0);
        check("bypass_no_clr", 128'(clr_cnt - clr0), 128'd0);
`endif

        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mix_col_seq.md
Name: mix_col_seq

Overview:
- Sequencer for the byte-serial MixColumns datapath (forward and inverse).
- Accepts a full 128-bit AES state over a valid/ready handshake and feeds it one byte per cycle into the datapath, column by column, clearing the datapath before each column.
- Captures the four result bytes after each column and returns the mixed state over a second valid/ready handshake.
- Sits between the round controller and the MixColumns datapath; the datapath's rst is driven by this block's mc_clr.

Parameters:
- NCOL, 4: columns per state; state width is 32*NCOL bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept a state
- in_mode  in  1  0 = forward MixColumns, 1 = inverse; sampled at accept
- in_state  in  32*NCOL  input state; byte k = bits [32*NCOL-1-8k -: 8]; column c = bytes 4c..4c+3; row r = byte 4c+r
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_state  out  32*NCOL  result state, same byte ordering as in_state
- busy  out  1  high in any state other than IDLE
- mc_d_in  out  8  byte to the datapath
- mc_en  out  1  datapath shift/accumulate enable
- mc_mode  out  1  datapath mode select
- mc_clr  out  1  datapath clear; drives the datapath rst
- mc_d0..mc_d3  in  8 each  datapath column outputs; mc_dr = result row r

Behaviour:
- FSM states: IDLE, CLR, FEED, CAPT, DONE. Registers: col counter (width clog2(NCOL), min 1 bit), row counter (2 bits), mode_q, in_buf, out_buf.
- Reset values: state = IDLE; out_valid = 0; out_state = 0; mc_en = 0; mc_d_in = 0; mc_mode = 0; counters = 0.
- mc_clr = rst OR (state == CLR), so the datapath is cleared while rst is high.
- in_ready = (state == IDLE) AND NOT rst. Handshakes are ignored while rst is high.
- IDLE: on in_valid && in_ready, latch in_state into in_buf and in_mode into mode_q; col = 0; go to CLR.
- CLR (1 cycle): mc_clr = 1, mc_en = 0; row = 0; go to FEED.
- FEED (4 cycles): mc_en = 1; mc_d_in = in_buf byte 4*col + row; mc_mode = mode_q; row increments each cycle. After row 3, go to CAPT.
- CAPT (1 cycle): mc_en = 0; at the clock edge, write mc_d0..mc_d3 into out_buf bytes 4*col+0..3.
  - If col == NCOL-1, go to DONE.
  - Otherwise col increments; go to CLR.
- DONE: out_valid = 1; out_state = out_buf, held stable until out_ready. On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- mc_mode holds mode_q in CLR, FEED and CAPT; it is 0 in IDLE.
- Latency: accept edge at end of cycle T gives out_valid high from cycle T+6*NCOL+1 (T+25 for NCOL = 4). Throughput is one state per 6*NCOL+2 cycles with out_ready tied high.
- in_valid, in_mode and in_state changes after accept have no effect on the block in flight.
- Single buffer: no new accept until the result handshake completes. In_ready rises the cycle after the out handshake.
- Reset at any point (including mid-FEED or in DONE) returns the block to IDLE the next cycle. The partial result is discarded and out_valid is 0.
- mc_* outputs are registered or derived only from state registers; there is no combinational path from in_* to mc_*.

Optional Feature:
- Macro: MC_SEQ_BYPASS_EN.
- Enabled:
  - Adds input port in_bypass (1 bit), sampled at accept.
  - If in_bypass is set, the block goes IDLE to DONE directly with out_buf = in_state. out_valid is high in cycle T+1.
  - No mc_en pulses and no mc_clr pulse are issued in bypass (used for the final AES round).
- Disabled: the port is absent and every accepted state is mixed.

Test Plan:
1. Forward mix: in_state = db135345_f20a225c_01010101_c6c6c6c6, mode 0, out_ready = 1 -> out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid first high exactly 25 cycles after the accept cycle; 16 mc_en pulses and 4 mc_clr pulses.
2. Inverse mix: in_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode 1 -> out_state = db135345_f20a225c_01010101_c6c6c6c6; mc_mode = 1 throughout CLR/FEED/CAPT.
3. Back-pressure: out_ready held 0 for 10 cycles after out_valid -> out_state stable, in_ready = 0 and in_valid ignored. Out_ready = 1 gives the handshake, and in_ready = 1 on the following cycle.
4. Reset mid-operation: assert rst for 1 cycle during FEED of column 2 -> next cycle IDLE, out_valid = 0, mc_clr = 1 during the rst cycle. A fresh vector from test 1 then produces the correct result.
5. Back-to-back: stream the two states of tests 1 and 2 with in_valid held high -> both results correct and in order; second accept occurs the cycle after the first out handshake.
6. Bypass (MC_SEQ_BYPASS_EN defined): in_bypass = 1, in_state = 00112233_44556677_8899aabb_ccddeeff -> identical out_state with out_valid at T+1; mc_en never asserted.
